// File: rtl/dot_types_pkg.sv
// Shared width constants and helpers for the dot_engine datapath.
package dot_types_pkg;

  localparam int unsigned DEF_A_WIDTH   = 8;
  localparam int unsigned DEF_B_WIDTH   = 8;
  localparam int unsigned DEF_OUT_WIDTH = 18;

  // Smallest accumulator width that holds a single full-precision product.
  function automatic int unsigned MIN_OUT_W(input int unsigned aw, input int unsigned bw);
    return aw + bw;
  endfunction

endpackage

// File: rtl/mac.sv
// Three-stage pipelined signed multiply-accumulate lane.
// Stage 1 registers the beat, stage 2 forms the full-precision product,
// stage 3 accumulates and publishes the frame sum on the eof beat.
module mac
  import dot_types_pkg::*;
#(
  parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
  parameter int unsigned B_WIDTH   = DEF_B_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic                        valid_in,
  input  logic                        eof,
  output logic signed [OUT_WIDTH-1:0] result,
  output logic                        valid_out
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  if (OUT_WIDTH < MIN_OUT_W(A_WIDTH, B_WIDTH)) begin : g_width_check
    $fatal(1, "mac: OUT_WIDTH must be at least A_WIDTH+B_WIDTH");
  end

  // Stage 1 state
  logic signed [A_WIDTH-1:0]   a_q;
  logic signed [B_WIDTH-1:0]   b_q;
  logic                        v1_q;
  logic                        e1_q;

  // Stage 2 state
  logic signed [P_WIDTH-1:0]   prod_q;
  logic signed [P_WIDTH-1:0]   prod_d;
  logic                        v2_q;
  logic                        e2_q;

  // Stage 3 state
  logic signed [OUT_WIDTH-1:0] acc_q;
  logic signed [OUT_WIDTH-1:0] acc_d;
  logic signed [OUT_WIDTH-1:0] result_q;
  logic signed [OUT_WIDTH-1:0] result_d;
  logic signed [OUT_WIDTH-1:0] sum_d;
  logic                        valid_q;
  logic                        valid_d;

  // Full-precision signed product of the registered operands.
  always_comb begin
    prod_d = P_WIDTH'(a_q) * P_WIDTH'(b_q);
  end

  // Accumulate step: eof publishes the sum and clears the accumulator in the
  // same edge, so a beat arriving right behind it starts from zero.
  always_comb begin
    sum_d    = acc_q + OUT_WIDTH'(prod_q);
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = 1'b0;
    if (v2_q) begin
      if (e2_q) begin
        result_d = sum_d;
        valid_d  = 1'b1;
        acc_d    = '0;
      end else begin
        acc_d    = sum_d;
      end
    end
  end

  // Stage 1: capture the incoming beat; eof only counts when the beat is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
      e1_q <= 1'b0;
    end else if (enable) begin
      a_q  <= a;
      b_q  <= b;
      v1_q <= valid_in;
      e1_q <= eof & valid_in;
    end
  end

  // Stage 2: register the product with its qualifiers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      v2_q   <= 1'b0;
      e2_q   <= 1'b0;
    end else if (enable) begin
      prod_q <= prod_d;
      v2_q   <= v1_q;
      e2_q   <= e1_q;
    end
  end

  // Stage 3: accumulator, held result and the one-cycle valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (enable) begin
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result    = result_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_mac.sv
// Scoreboard bench for the mac lane: the driver pushes hand-computed frame
// sums with the enabled-edge index at which they must appear; a monitor pops
// and compares on every fresh valid_out.
module tb_mac;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic signed [7:0]  a = '0;
  logic signed [7:0]  b = '0;
  logic               valid_in = 1'b0;
  logic               eof = 1'b0;
  logic signed [17:0] result;
  logic               valid_out;

  typedef struct {
    logic signed [17:0] val;
    int unsigned        edge_idx;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned ecount = 0;
  int unsigned last_mon = 0;

  mac #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(18)) dut (
    .clk(clk), .reset(reset), .enable(enable), .a(a), .b(b),
    .valid_in(valid_in), .eof(eof), .result(result), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // Count edges at which the pipeline actually advanced.
  always @(posedge clk) begin
    if (enable && !reset) ecount <= ecount + 1;
  end

  // Monitor: each new valid_out after an enabled edge must match the queue head.
  always @(negedge clk) begin
    if (!reset && valid_out && ecount != last_mon) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid_out: result=%0d at edge %0d, required no output", result, ecount);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (result !== e.val) begin
          failures++;
          $display("FAIL result_value: got %0d, required %0d", result, e.val);
        end
        checks++;
        if (ecount != e.edge_idx) begin
          failures++;
          $display("FAIL result_latency: edge %0d, required edge %0d", ecount, e.edge_idx);
        end
      end
    end
    last_mon <= ecount;
  end

  task automatic beat(input logic signed [7:0] av, input logic signed [7:0] bv,
                      input logic v, input logic e, input logic signed [17:0] exp_v);
    @(negedge clk);
    enable   = 1'b1;
    a        = av;
    b        = bv;
    valid_in = v;
    eof      = e;
    if (v && e) sb.push_back('{exp_v, ecount + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable   = 1'b1;
      valid_in = 1'b0;
      eof      = 1'b0;
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      enable   = 1'b0;
      valid_in = 1'b0;
      eof      = 1'b0;
    end
  endtask

  task automatic check_direct(input string name, input logic signed [17:0] got,
                              input logic signed [17:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    // Asynchronous reset without any clock edge.
    #1 reset = 1'b1;
    #1;
    check_direct("reset_result", result, 18'sd0);
    check_direct("reset_valid", {17'd0, valid_out}, 18'sd0);
    @(negedge clk);
    reset = 1'b0;

    // Two-beat frame: 3*5 + (-4)*7 = -13.
    beat(8'sd3, 8'sd5, 1'b1, 1'b0, 18'sd0);
    beat(-8'sd4, 8'sd7, 1'b1, 1'b1, -18'sd13);
    idle(4);

    // Extremes: 2 * 16384 = 32768, then single beat 127*-128 = -16256.
    beat(-8'sd128, -8'sd128, 1'b1, 1'b0, 18'sd0);
    beat(-8'sd128, -8'sd128, 1'b1, 1'b1, 18'sd32768);
    idle(3);
    beat(8'sd127, -8'sd128, 1'b1, 1'b1, -18'sd16256);
    idle(4);

    // Back-to-back frames: {2*2,3*3} = 13 then {1*1} = 1.
    beat(8'sd2, 8'sd2, 1'b1, 1'b0, 18'sd0);
    beat(8'sd3, 8'sd3, 1'b1, 1'b1, 18'sd13);
    beat(8'sd1, 8'sd1, 1'b1, 1'b1, 18'sd1);
    idle(4);

    // Stall mid-frame for 4 cycles: 1+4+9 = 14.
    beat(8'sd1, 8'sd1, 1'b1, 1'b0, 18'sd0);
    beat(8'sd2, 8'sd2, 1'b1, 1'b0, 18'sd0);
    stall(4);
    beat(8'sd3, 8'sd3, 1'b1, 1'b1, 18'sd14);
    idle(4);

    // Stall right after a pulse: valid_out frozen, must not double-count.
    beat(8'sd2, -8'sd3, 1'b1, 1'b1, -18'sd6);
    idle(2);
    stall(3);
    idle(3);

    // Gap carrying a stray eof (valid_in=0) is ignored: 25 + (-6) = 19.
    beat(8'sd5, 8'sd5, 1'b1, 1'b0, 18'sd0);
    beat(8'sd9, 8'sd9, 1'b0, 1'b1, 18'sd0);
    idle(2);
    beat(-8'sd2, 8'sd3, 1'b1, 1'b1, 18'sd19);
    idle(4);

    // Reset mid-frame, mid-cycle: outputs clear at once, in-flight beats dropped.
    beat(8'sd10, 8'sd10, 1'b1, 1'b0, 18'sd0);
    beat(8'sd11, 8'sd11, 1'b1, 1'b0, 18'sd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_direct("midreset_result", result, 18'sd0);
    check_direct("midreset_valid", {17'd0, valid_out}, 18'sd0);
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b0;
    eof      = 1'b0;
    beat(8'sd2, 8'sd3, 1'b1, 1'b1, 18'sd6);
    idle(6);

    // Bounded drain of anything still expected.
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_output: no valid_out, required result %0d", e.val);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
